// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates in program order, accepts out-of-order CDB results, commits in order
// and flushes on branch mispredict. Define ROB_COMMIT_CNT_EN to add the rob_commit_cnt output.
module reorder_buffer #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int XLEN           = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      dec_ready,
    input  logic                      stall,
    input  logic                      dec_has_rd,
    input  logic [4:0]                dec_rd,
    input  logic                      dec_is_branch,
    input  logic                      dec_pred_taken,
    input  logic [XLEN-1:0]           dec_alt_pc,
    input  logic                      cdb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] cdb_id,
    input  logic [XLEN-1:0]           cdb_val,
    input  logic                      cdb_taken,
    output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
    output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
    output logic                      rob_full,
    output logic                      rob_rf_enable,
    output logic [4:0]                rob_rf_rd,
    output logic [XLEN-1:0]           rob_rf_val,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc
`ifdef ROB_COMMIT_CNT_EN
    ,
    output logic [31:0]               rob_commit_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0]   FULL_COUNT = (ROB_SIZE_WIDTH + 1)'(DEPTH);
    localparam logic [ROB_SIZE_WIDTH:0]   COUNT_ONE  = (ROB_SIZE_WIDTH + 1)'(1);
    localparam logic [ROB_SIZE_WIDTH-1:0] ID_ONE     = ROB_SIZE_WIDTH'(1);

    logic [ROB_SIZE_WIDTH-1:0] head;
    logic [ROB_SIZE_WIDTH-1:0] tail;
    logic [ROB_SIZE_WIDTH:0]   count;
    logic [DEPTH-1:0]          busy;
    logic [DEPTH-1:0]          ready;

    logic                has_rd_q     [DEPTH];
    logic [4:0]          rd_q         [DEPTH];
    logic                is_branch_q  [DEPTH];
    logic                pred_taken_q [DEPTH];
    logic [XLEN-1:0]     alt_pc_q     [DEPTH];
    logic [XLEN-1:0]     value_q      [DEPTH];
    logic                taken_q      [DEPTH];

    logic alloc;
    logic commit;
    logic mispredict;
    logic cdb_hit;

    assign rob_head_id = head;
    assign rob_tail_id = tail;
    assign rob_full    = (count == FULL_COUNT);

    // The flush cycle is dead time: nothing allocates, writes back or commits.
    always_comb begin
        alloc      = dec_ready && !stall && !rob_full && !flush;
        commit     = (count != '0) && ready[head] && !flush;
        mispredict = commit && is_branch_q[head] && (taken_q[head] != pred_taken_q[head]);
        cdb_hit    = cdb_valid && busy[cdb_id] && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            ready         <= '0;
            rob_rf_enable <= 1'b0;
            rob_rf_rd     <= '0;
            rob_rf_val    <= '0;
            flush         <= 1'b0;
            flush_pc      <= '0;
        end else if (rdy) begin
            if (flush) begin
                flush         <= 1'b0;
                rob_rf_enable <= 1'b0;
            end else if (mispredict) begin
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                busy          <= '0;
                ready         <= '0;
                flush         <= 1'b1;
                flush_pc      <= alt_pc_q[head];
                rob_rf_enable <= 1'b0;
            end else begin
                rob_rf_enable <= commit && has_rd_q[head];
                if (cdb_hit) begin
                    ready[cdb_id] <= 1'b1;
                end
                if (alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + ID_ONE;
                end
                // Commit clears last so a same-cycle CDB write to head cannot revive it.
                if (commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + ID_ONE;
                    rob_rf_rd   <= rd_q[head];
                    rob_rf_val  <= value_q[head];
                end
                case ({alloc, commit})
                    2'b10:   count <= count + COUNT_ONE;
                    2'b01:   count <= count - COUNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !mispredict) begin
            if (alloc) begin
                has_rd_q[tail]     <= dec_has_rd;
                rd_q[tail]         <= dec_rd;
                is_branch_q[tail]  <= dec_is_branch;
                pred_taken_q[tail] <= dec_pred_taken;
                alt_pc_q[tail]     <= dec_alt_pc;
            end
            if (cdb_hit) begin
                value_q[cdb_id] <= cdb_val;
                taken_q[cdb_id] <= cdb_taken;
            end
        end
    end

`ifdef ROB_COMMIT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_commit_cnt <= '0;
        end else if (rdy && commit) begin
            rob_commit_cnt <= rob_commit_cnt + 32'd1;
        end
    end
`endif

endmodule
